// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and helpers for the reset sequencer
// Purpose: state encoding for rst_sequencer plus a constant helper used to
//          size its counter.
// Ports:   none (package).
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - lock/soft-reset inputs and sequenced reset outputs
// Purpose: bundles the sequencer's functional signals.
// Ports:   lock_i (PLL lock, async), soft_rst_i (sync pulse),
//          rst_n_o (active-low domain resets), done_o, busy_o.
//          master = sequencer side, slave = surrounding clk/rst logic.
interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   lock_i;
  logic                   soft_rst_i;
  logic [NUM_DOMAINS-1:0] rst_n_o;
  logic                   done_o;
  logic                   busy_o;

  modport master (
    input  lock_i,
    input  soft_rst_i,
    output rst_n_o,
    output done_o,
    output busy_o
  );

  modport slave (
    output lock_i,
    output soft_rst_i,
    input  rst_n_o,
    input  done_o,
    input  busy_o
  );
endinterface

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer with async active-low reset
// Purpose: brings an asynchronous level into the clk domain (2-cycle latency).
// Ports:   clk, rst_n (async active-low), d_i (async input), q_o (synchronized).
module bit_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - power-on / soft-reset sequencer for downstream domains
// Purpose: holds all domain resets asserted, waits for PLL lock, then releases
//          domains 0..NUM_DOMAINS-1 one at a time, GAP_CYCLES apart. Lock loss
//          or a soft reset request throws every domain back into reset.
// Ports:   clk, rst_n (async active-low), sif (master modport): lock_i,
//          soft_rst_i in; rst_n_o, done_o, busy_o out (all registered).
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rst_sequencer_if.master sif
);
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic lock_s;

  state_e                 state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [IDX_W-1:0]       idx_d, idx_q;
  logic [NUM_DOMAINS-1:0] rst_n_d, rst_n_q;
  logic                   done_d, done_q;
  logic                   busy_d, busy_q;

  bit_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sif.lock_i),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;

    case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        // A soft request here restarts the hold window rather than extending it.
        if (sif.soft_rst_i) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        rst_n_d = '0;
        if (lock_s) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_RELEASE: begin
        // Lock loss and soft request share one re-assert path, so both at
        // once still yields a single hold window.
        if (sif.soft_rst_i || !lock_s) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        rst_n_d = '1;
        if (sif.soft_rst_i || !lock_s) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        idx_d   = '0;
        rst_n_d = '0;
      end
    endcase

    // Status flags follow the next state so they change on the same edge as
    // the final release / re-assert.
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sif.rst_n_o = rst_n_q;
  assign sif.done_o  = done_q;
  assign sif.busy_o  = busy_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - self-checking bench for rst_sequencer
module tb_rst_sequencer;
  localparam int N = 4;
  localparam int H = 8;
  localparam int G = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rst_sequencer_if #(.NUM_DOMAINS(N)) sif ();

  rst_sequencer #(
    .NUM_DOMAINS (N),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference model: timestamps of the last entry into the hold window and of
  // the lock-acquire edge; released bits follow from plain arithmetic.
  int t0;
  int t_lock;
  bit rel_phase;
  bit lock_dly[$];

  typedef struct {
    int         edge_no;
    logic [3:0] rst;
    logic       done;
    logic       busy;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [31:0] pack(input logic [3:0] r, input logic d, input logic b);
    return {26'b0, r, d, b};
  endfunction

  function automatic logic [31:0] outv();
    return pack(sif.rst_n_o, sif.done_o, sif.busy_o);
  endfunction

  function automatic logic [3:0] model_rst();
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (rel_phase && edge_n >= t_lock + (k + 1) * G) r[k] = 1'b1;
    return r;
  endfunction

  function automatic void model_reset();
    t0 = 0;
    t_lock = 0;
    rel_phase = 0;
    lock_dly = {1'b0, 1'b0};
  endfunction

  function automatic void model_edge();
    bit ls;
    ls = lock_dly.pop_front();
    lock_dly.push_back(sif.lock_i);
    if (rel_phase) begin
      if (sif.soft_rst_i || !ls) begin
        rel_phase = 0;
        t0 = edge_n;
      end
    end else if (edge_n <= t0 + H) begin
      if (sif.soft_rst_i) t0 = edge_n;
    end else if (ls) begin
      rel_phase = 1;
      t_lock = edge_n;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_check(input string nm);
    logic [3:0] r;
    logic d;
    r = model_rst();
    d = (r == 4'hF);
    check(nm, outv(), pack(r, d, !d));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    model_check("model");
  endtask

  task automatic wait_bit(input int k, input int budget, output int e);
    int n;
    n = 0;
    while (sif.rst_n_o[k] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (sif.rst_n_o[k] !== 1'b1) check($sformatf("timeout_bit%0d", k), 32'd0, 32'd1);
    e = edge_n;
  endtask

  task automatic do_reset(input logic lk);
    @(negedge clk);
    rst_n = 1'b0;
    sif.soft_rst_i = 1'b0;
    sif.lock_i = lk;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    edge_n = 0;
    check("reset_state", outv(), pack(4'b0000, 1'b0, 1'b1));
    rst_n = 1'b1;
  endtask

  initial begin
    int e, r;
    sif.lock_i = 1'b1;
    sif.soft_rst_i = 1'b0;

    tbl[0] = '{24, 4'b0000, 1'b0, 1'b1};
    tbl[1] = '{25, 4'b0001, 1'b0, 1'b1};
    tbl[2] = '{40, 4'b0001, 1'b0, 1'b1};
    tbl[3] = '{41, 4'b0011, 1'b0, 1'b1};
    tbl[4] = '{56, 4'b0011, 1'b0, 1'b1};
    tbl[5] = '{57, 4'b0111, 1'b0, 1'b1};
    tbl[6] = '{72, 4'b0111, 1'b0, 1'b1};
    tbl[7] = '{73, 4'b1111, 1'b1, 1'b0};
    tbl[8] = '{80, 4'b1111, 1'b1, 1'b0};
    tbl[9] = '{120, 4'b1111, 1'b1, 1'b0};

    // Power-on with lock already present.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      while (edge_n < tbl[i].edge_no) tick();
      check($sformatf("tbl_edge%0d", tbl[i].edge_no), outv(),
            pack(tbl[i].rst, tbl[i].done, tbl[i].busy));
    end

    // Soft reset in DONE replays the full sequence.
    sif.soft_rst_i = 1'b1;
    tick();
    sif.soft_rst_i = 1'b0;
    r = edge_n;
    check("soft_reassert", outv(), pack(4'b0000, 1'b0, 1'b1));
    wait_bit(0, 100, e);
    check("soft_bit0_edge", e - r, 25);
    wait_bit(1, 100, e);
    check("soft_bit1_edge", e - r, 41);
    wait_bit(3, 100, e);
    check("soft_done_edge", e - r, 73);
    check("soft_done_out", outv(), pack(4'b1111, 1'b1, 1'b0));

    // Lock loss in RELEASE after bit 1.
    sif.soft_rst_i = 1'b1;
    tick();
    sif.soft_rst_i = 1'b0;
    wait_bit(1, 100, e);
    sif.lock_i = 1'b0;
    tick();
    tick();
    check("lock_drop_2edges", outv(), pack(4'b0011, 1'b0, 1'b1));
    tick();
    r = edge_n;
    check("lock_drop_3edges", outv(), pack(4'b0000, 1'b0, 1'b1));
    sif.lock_i = 1'b1;
    wait_bit(0, 100, e);
    check("relock_bit0_edge", e - r, 25);
    check("relock_order", outv(), pack(4'b0001, 1'b0, 1'b1));

    // Simultaneous lock loss and soft request: one re-assert, one hold.
    wait_bit(3, 200, e);
    sif.lock_i = 1'b0;
    tick();
    tick();
    sif.soft_rst_i = 1'b1;
    tick();
    sif.soft_rst_i = 1'b0;
    sif.lock_i = 1'b1;
    r = edge_n;
    check("simul_reassert", outv(), pack(4'b0000, 1'b0, 1'b1));
    wait_bit(0, 100, e);
    check("simul_bit0_edge", e - r, 25);

    // Lock absent for 100 cycles after reset.
    do_reset(1'b0);
    repeat (100) tick();
    check("no_lock_hold", outv(), pack(4'b0000, 1'b0, 1'b1));
    sif.lock_i = 1'b1;
    r = edge_n;
    wait_bit(0, 100, e);
    check("late_lock_bit0", e - r, 19);

    // Asynchronous reset between clock edges mid-RELEASE.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outv(), pack(4'b0000, 1'b0, 1'b1));
    @(negedge clk);
    check("async_rst_hold", outv(), pack(4'b0000, 1'b0, 1'b1));
    model_reset();
    edge_n = 0;
    rst_n = 1'b1;
    wait_bit(0, 100, e);
    check("post_async_bit0", e, 25);

    // Randomized lock/soft activity against the model.
    for (int i = 0; i < 4000; i++) begin
      if (sif.lock_i) sif.lock_i = ($urandom_range(0, 149) != 0);
      else            sif.lock_i = ($urandom_range(0, 9) == 0);
      sif.soft_rst_i = ($urandom_range(0, 249) == 0);
      tick();
    end
    sif.soft_rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
